// File: rtl/prbs_pkg.sv
// PRBS generator shared definitions: order selects, polynomial lengths/taps,
// the all-ones seed and the layout of the runtime configuration word.
package prbs_pkg;

    localparam int STATE_W = 31;

    localparam logic [2:0] SEL_PRBS7  = 3'd0;
    localparam logic [2:0] SEL_PRBS9  = 3'd1;
    localparam logic [2:0] SEL_PRBS15 = 3'd2;
    localparam logic [2:0] SEL_PRBS23 = 3'd3;
    localparam logic [2:0] SEL_PRBS31 = 3'd4;
    localparam logic [2:0] SEL_MAX    = SEL_PRBS31;

    localparam logic [STATE_W-1:0] SEED = '1;

    localparam int CFG_SEL_LSB = 0;
    localparam int CFG_SEL_W   = 3;
    localparam int CFG_INV_BIT = 3;
    localparam int CFG_CLR_BIT = 4;
    localparam int CFG_DIV_LSB = 8;
    localparam int CFG_DIV_W   = 24;

    typedef struct packed {
        logic [CFG_SEL_W-1:0] sel;
        logic                 inv;
        logic [CFG_DIV_W-1:0] div;
    } cfg_t;

    function automatic logic [4:0] prbs_len(input logic [2:0] sel);
        case (sel)
            SEL_PRBS7:  return 5'd7;
            SEL_PRBS9:  return 5'd9;
            SEL_PRBS15: return 5'd15;
            SEL_PRBS23: return 5'd23;
            default:    return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [2:0] sel);
        case (sel)
            SEL_PRBS7:  return 5'd6;
            SEL_PRBS9:  return 5'd5;
            SEL_PRBS15: return 5'd14;
            SEL_PRBS23: return 5'd18;
            default:    return 5'd28;
        endcase
    endfunction

    // Seed restricted to the active register length; doubles as the live-bit mask.
    function automatic logic [STATE_W-1:0] prbs_mask(input logic [2:0] sel);
        return SEED >> (5'd31 - prbs_len(sel));
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational LANES-bit advance of the selected Fibonacci LFSR; bit 0 is the oldest
// new bit. Pure logic: no latency, no flow control.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic [2:0]         sel,
    input  logic               inv,
    input  logic [STATE_W-1:0] state_i,
    output logic [STATE_W-1:0] state_o,
    output logic [LANES-1:0]   bits_o
);

    logic [4:0]         len;
    logic [4:0]         tap;
    logic [STATE_W-1:0] mask;
    logic [STATE_W-1:0] s;
    logic               nb;

    always_comb begin
        len    = prbs_len(sel);
        tap    = prbs_tap(sel);
        mask   = prbs_mask(sel);
        s      = state_i;
        nb     = 1'b0;
        bits_o = '0;
        for (int i = 0; i < LANES; i++) begin
            nb        = s[len - 5'd1] ^ s[tap - 5'd1];
            bits_o[i] = nb ^ inv;
            s         = {s[STATE_W-2:0], nb} & mask;
        end
        state_o = s;
    end

endmodule

// File: rtl/prbs_gen_axis.sv
// PRBS source on AXI-Stream; beat registered 1 cycle after each divider tick.
// Never stalls: a tick onto an unaccepted beat overwrites it and sets sticky overflow.
module prbs_gen_axis
    import prbs_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int LANES            = 1,
    parameter int VAR              = 0,
    parameter int PRBS_SEL         = 4,
    parameter int DEFAULT_DIV      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PARAM_tdata,
    input  logic                        S_AXIS_PARAM_tvalid,
    output logic                        S_AXIS_PARAM_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_PRBS_tdata,
    output logic                        M_AXIS_PRBS_tvalid,
    input  logic                        M_AXIS_PRBS_tready,
    output logic                        PRBS,
    output logic                        sync,
    output logic                        overflow,
    output logic                        cfg_err
);

    localparam cfg_t CFG_RST = '{sel: 3'(PRBS_SEL), inv: 1'b0, div: CFG_DIV_W'(DEFAULT_DIV)};

    logic [CFG_DIV_W-1:0]        cnt_q, cnt_d;
    logic [STATE_W-1:0]          state_q, state_d;
    logic [STATE_W-1:0]          start_state, step_state;
    cfg_t                        cfg_q, cfg_d, shd_q, shd_d, cfg_eff, word_cfg;
    logic                        shd_vld_q, shd_vld_d;
    logic                        tvalid_q, tvalid_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        prbs_q, prbs_d;
    logic                        sync_q, sync_d;
    logic                        ovf_q, ovf_d;
    logic                        err_q, err_d;
    logic [LANES-1:0]            step_bits;
    logic                        tick, word_vld, word_ok, word_bad, word_clr;
    logic                        unused_param_bits;

    assign word_cfg = '{sel: S_AXIS_PARAM_tdata[CFG_SEL_LSB +: CFG_SEL_W],
                        inv: S_AXIS_PARAM_tdata[CFG_INV_BIT],
                        div: S_AXIS_PARAM_tdata[CFG_DIV_LSB +: CFG_DIV_W]};
    assign unused_param_bits = ^S_AXIS_PARAM_tdata[CFG_DIV_LSB-1:CFG_CLR_BIT+1];

    assign word_vld = (VAR != 0) && S_AXIS_PARAM_tvalid;
    assign word_ok  = word_vld && (word_cfg.sel <= SEL_MAX);
    assign word_bad = word_vld && (word_cfg.sel > SEL_MAX);
    assign word_clr = word_ok && S_AXIS_PARAM_tdata[CFG_CLR_BIT];

    assign tick    = (cnt_q == cfg_q.div);
    // A staged word takes effect on the tick edge itself, so this tick already uses it.
    assign cfg_eff = (tick && shd_vld_q) ? shd_q : cfg_q;
    assign start_state = ((cfg_eff.sel != cfg_q.sel) || (state_q == '0))
                       ? prbs_mask(cfg_eff.sel) : state_q;

    prbs_lfsr_step #(.LANES(LANES)) u_step (
        .sel     (cfg_eff.sel),
        .inv     (cfg_eff.inv),
        .state_i (start_state),
        .state_o (step_state),
        .bits_o  (step_bits)
    );

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        state_d   = state_q;
        cfg_d     = cfg_q;
        shd_d     = shd_q;
        shd_vld_d = shd_vld_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        prbs_d    = prbs_q;
        sync_d    = tick && (step_state == prbs_mask(cfg_eff.sel));

        if (tick) begin
            cfg_d    = cfg_eff;
            state_d  = step_state;
            tdata_d  = AXIS_TDATA_WIDTH'(step_bits);
            prbs_d   = step_bits[LANES-1];
            tvalid_d = 1'b1;
        end else if (M_AXIS_PRBS_tready) begin
            tvalid_d = 1'b0;
        end

        if (word_ok) begin
            shd_d     = word_cfg;
            shd_vld_d = 1'b1;
        end else if (tick) begin
            shd_vld_d = 1'b0;
        end

        ovf_d = (tick && tvalid_q && !M_AXIS_PRBS_tready) || (ovf_q && !word_clr);
        err_d = word_bad || (err_q && !word_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            state_q   <= prbs_mask(3'(PRBS_SEL));
            cfg_q     <= CFG_RST;
            shd_q     <= CFG_RST;
            shd_vld_q <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            prbs_q    <= 1'b0;
            sync_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            shd_q     <= shd_d;
            shd_vld_q <= shd_vld_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            prbs_q    <= prbs_d;
            sync_q    <= sync_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign S_AXIS_PARAM_tready = 1'b1;
    assign M_AXIS_PRBS_tdata   = tdata_q;
    assign M_AXIS_PRBS_tvalid  = tvalid_q;
    assign PRBS                = prbs_q;
    assign sync                = sync_q;
    assign overflow            = ovf_q;
    assign cfg_err             = err_q;

endmodule

// File: tb/tb_prbs_gen_axis.sv
// Bench: runtime-config single-lane instance plus a fixed-config 8-lane instance,
// both checked against a recurrence-based PRBS sequence model.
module tb_prbs_gen_axis;

    logic        clk = 1'b0;
    always #4 clk = ~clk;

    logic        rst_a, pa_vld, pa_rdy, ma_vld, ma_rdy, prbs_a, sync_a, ovf_a, err_a;
    logic [31:0] pa_dat, ma_dat;
    logic        rst_b, pb_vld, pb_rdy, mb_vld, mb_rdy, prbs_b, sync_b, ovf_b, err_b;
    logic [31:0] pb_dat, mb_dat;

    prbs_gen_axis #(.AXIS_TDATA_WIDTH(32), .LANES(1), .VAR(1), .PRBS_SEL(0), .DEFAULT_DIV(0)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .S_AXIS_PARAM_tdata(pa_dat), .S_AXIS_PARAM_tvalid(pa_vld), .S_AXIS_PARAM_tready(pa_rdy),
        .M_AXIS_PRBS_tdata(ma_dat), .M_AXIS_PRBS_tvalid(ma_vld), .M_AXIS_PRBS_tready(ma_rdy),
        .PRBS(prbs_a), .sync(sync_a), .overflow(ovf_a), .cfg_err(err_a)
    );

    prbs_gen_axis #(.AXIS_TDATA_WIDTH(32), .LANES(8), .VAR(0), .PRBS_SEL(1), .DEFAULT_DIV(0)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .S_AXIS_PARAM_tdata(pb_dat), .S_AXIS_PARAM_tvalid(pb_vld), .S_AXIS_PARAM_tready(pb_rdy),
        .M_AXIS_PRBS_tdata(mb_dat), .M_AXIS_PRBS_tvalid(mb_vld), .M_AXIS_PRBS_tready(mb_rdy),
        .PRBS(prbs_b), .sync(sync_b), .overflow(ovf_b), .cfg_err(err_b)
    );

    int tests_run, tests_failed;
    bit seq_q[$];
    bit r7[$], r9[$], r15[$], r31[$];

    // Serial reference: bit k = bit(k-n) XOR bit(k-t), with n ones preceding the stream.
    task automatic gen_seq(input int n, input int t, input int len);
        bit h[$];
        h = {};
        for (int i = 0; i < n; i++) h.push_back(1'b1);
        for (int k = 0; k < len; k++) h.push_back(h[h.size() - n] ^ h[h.size() - t]);
        seq_q = {};
        for (int k = n; k < h.size(); k++) seq_q.push_back(h[k]);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int   bad_bits, bad_sync, bad_vld, ones, nsync, n;
    logic [6:0]  first7;
    logic [31:0] held, exp_dat;
    logic        eb, es, ovf_exp;

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        pa_vld = 1'b0; pa_dat = '0; ma_rdy = 1'b1;
        pb_vld = 1'b0; pb_dat = '0; mb_rdy = 1'b1;
        gen_seq(7, 6, 300);   r7  = seq_q;
        gen_seq(9, 5, 4096);  r9  = seq_q;
        gen_seq(15, 14, 64);  r15 = seq_q;
        gen_seq(31, 28, 64);  r31 = seq_q;
        repeat (3) step_clk();

        check("rst_tvalid", 64'(ma_vld), 0);
        check("rst_tdata", 64'(ma_dat), 0);
        check("rst_prbs", 64'(prbs_a), 0);
        check("rst_sync", 64'(sync_a), 0);
        check("rst_overflow", 64'(ovf_a), 0);
        check("rst_cfg_err", 64'(err_a), 0);
        check("param_tready", 64'(pa_rdy), 1);

        // PRBS7, tick every cycle, sink always ready
        rst_a = 1'b0;
        bad_bits = 0; bad_sync = 0; bad_vld = 0; ones = 0; nsync = 0; first7 = '0;
        for (int k = 1; k <= 254; k++) begin
            step_clk();
            eb = r7[k-1];
            es = (k % 127 == 0);
            if (ma_dat !== {31'b0, eb} || prbs_a !== eb) bad_bits++;
            if (sync_a !== es) bad_sync++;
            if (ma_vld !== 1'b1) bad_vld++;
            if (k <= 127 && prbs_a === 1'b1) ones++;
            if (sync_a === 1'b1) nsync++;
            if (k <= 7) first7[k-1] = prbs_a;
        end
        check("prbs7_bits", 64'(bad_bits), 0);
        check("prbs7_first7", 64'(first7), 64'h40);
        check("prbs7_ones", 64'(ones), 64);
        check("prbs7_sync_pos", 64'(bad_sync), 0);
        check("prbs7_sync_cnt", 64'(nsync), 2);
        check("prbs7_tvalid", 64'(bad_vld), 0);
        check("prbs7_no_ovf", 64'(ovf_a), 0);

        // PRBS31 inverted, N=9
        pa_dat = (32'd9 << 8) | (32'd1 << 3) | 32'd4; pa_vld = 1'b1;
        step_clk();
        pa_vld = 1'b0;
        step_clk();
        eb = ~r31[0];
        check("p31_first_bit", 64'(prbs_a), 64'(eb));
        check("p31_first_vld", 64'(ma_vld), 1);
        bad_bits = 0; bad_vld = 0;
        for (int j = 1; j <= 40; j++) begin
            step_clk();
            eb = ~r31[j / 10];
            if (ma_vld !== (j % 10 == 0)) bad_vld++;
            if (prbs_a !== eb || ma_dat !== {31'b0, eb}) bad_bits++;
        end
        check("p31_div10_vld", 64'(bad_vld), 0);
        check("p31_div10_bits", 64'(bad_bits), 0);

        // Backpressure across two ticks
        ma_rdy = 1'b0;
        held = ma_dat;
        bad_bits = 0;
        for (int j = 1; j <= 9; j++) begin
            step_clk();
            if (ma_vld !== 1'b1 || ma_dat !== held || ovf_a !== 1'b0) bad_bits++;
        end
        check("stall_hold", 64'(bad_bits), 0);
        step_clk();
        eb = ~r31[5];
        check("stall_replace", 64'(ma_dat), 64'({31'b0, eb}));
        check("stall_vld", 64'(ma_vld), 1);
        check("stall_ovf", 64'(ovf_a), 1);
        repeat (10) step_clk();
        eb = ~r31[6];
        check("stall_replace2", 64'(ma_dat), 64'({31'b0, eb}));
        check("stall_ovf_sticky", 64'(ovf_a), 1);
        ma_rdy = 1'b1;
        pa_dat = (32'd9 << 8) | (32'd1 << 4) | (32'd1 << 3) | 32'd4; pa_vld = 1'b1;
        step_clk();
        pa_vld = 1'b0;
        check("ovf_cleared", 64'(ovf_a), 0);
        check("handshake_drop", 64'(ma_vld), 0);

        // Same-sel word must not reseed
        n = 0;
        do begin step_clk(); n++; end while (ma_vld !== 1'b1 && n < 20);
        check("wait_tick_a", 64'(ma_vld), 1);
        eb = ~r31[7];
        check("same_sel_no_reseed", 64'(prbs_a), 64'(eb));

        // Two staged words mid-interval; the later one (PRBS15, N=3) applies at the tick
        repeat (3) step_clk();
        pa_dat = (32'd5 << 8) | 32'd3; pa_vld = 1'b1;
        step_clk();
        pa_dat = (32'd3 << 8) | 32'd2;
        step_clk();
        pa_vld = 1'b0;
        n = 0; bad_bits = 0;
        eb = ~r31[7];
        do begin
            step_clk(); n++;
            if (ma_vld !== 1'b1 && prbs_a !== eb) bad_bits++;
        end while (ma_vld !== 1'b1 && n < 20);
        check("staged_not_early", 64'(bad_bits), 0);
        check("old_div_until_tick", 64'(n), 5);
        eb = r15[0];
        check("p15_first_bit", 64'(prbs_a), 64'(eb));
        bad_bits = 0; bad_vld = 0;
        for (int t = 1; t <= 5; t++) begin
            repeat (3) begin step_clk(); if (ma_vld !== 1'b0) bad_vld++; end
            step_clk();
            eb = r15[t];
            if (ma_vld !== 1'b1) bad_vld++;
            if (prbs_a !== eb || ma_dat !== {31'b0, eb}) bad_bits++;
        end
        check("p15_div4_vld", 64'(bad_vld), 0);
        check("p15_bits", 64'(bad_bits), 0);

        // Reserved sel: ignored, sets cfg_err
        pa_dat = (32'd9 << 8) | 32'd6; pa_vld = 1'b1;
        step_clk();
        pa_vld = 1'b0;
        check("cfg_err_set", 64'(err_a), 1);
        repeat (3) step_clk();
        eb = r15[6];
        check("reserved_ignored", 64'(prbs_a), 64'(eb));
        check("reserved_ignored_vld", 64'(ma_vld), 1);
        pa_dat = (32'd3 << 8) | (32'd1 << 4) | 32'd7; pa_vld = 1'b1;
        step_clk();
        check("cfg_err_set_wins", 64'(err_a), 1);
        pa_dat = (32'd3 << 8) | (32'd1 << 4) | 32'd2;
        step_clk();
        pa_vld = 1'b0;
        check("cfg_err_cleared", 64'(err_a), 0);
        step_clk();
        step_clk();
        eb = r15[7];
        check("p15_continue", 64'(prbs_a), 64'(eb));

        // Asynchronous reset with a pending beat
        ma_rdy = 1'b0;
        step_clk();
        check("pending_beat", 64'(ma_vld), 1);
        #2 rst_a = 1'b1;
        #1;
        check("arst_tvalid", 64'(ma_vld), 0);
        check("arst_tdata", 64'(ma_dat), 0);
        check("arst_prbs", 64'(prbs_a), 0);
        check("arst_flags", 64'({sync_a, ovf_a, err_a}), 0);
        ma_rdy = 1'b1;
        step_clk();
        step_clk();
        rst_a = 1'b0;
        bad_bits = 0;
        for (int k = 1; k <= 30; k++) begin
            step_clk();
            eb = r7[k-1];
            if (prbs_a !== eb || ma_dat !== {31'b0, eb} || ma_vld !== 1'b1) bad_bits++;
        end
        check("post_reset_seq", 64'(bad_bits), 0);

        // 8 lanes of PRBS9 vs the serial reference, random sink and random ignored params
        check("b_rst_tvalid", 64'(mb_vld), 0);
        check("b_rst_tdata", 64'(mb_dat), 0);
        pb_vld = 1'b1; pb_dat = 32'h0000_0017;
        rst_b = 1'b0;
        ovf_exp = 1'b0;
        bad_bits = 0; bad_sync = 0; bad_vld = 0; nsync = 0; n = 0;
        for (int k = 1; k <= 511; k++) begin
            step_clk();
            exp_dat = '0;
            for (int i = 0; i < 8; i++) exp_dat[i] = r9[(k-1)*8 + i];
            es = (k == 511);
            if (mb_dat !== exp_dat || prbs_b !== exp_dat[7]) bad_bits++;
            if (sync_b !== es) bad_sync++;
            if (sync_b === 1'b1) nsync++;
            if (mb_vld !== 1'b1) bad_vld++;
            if (ovf_b !== ovf_exp) n++;
            mb_rdy = ($urandom_range(0, 3) != 0);
            if (!mb_rdy) ovf_exp = 1'b1;
            pb_vld = 1'($urandom_range(0, 1));
            pb_dat = $urandom;
        end
        check("lanes8_bits", 64'(bad_bits), 0);
        check("lanes8_sync_pos", 64'(bad_sync), 0);
        check("lanes8_sync_cnt", 64'(nsync), 1);
        check("lanes8_tvalid", 64'(bad_vld), 0);
        check("lanes8_overflow", 64'(n), 0);
        check("var0_no_cfg_err", 64'(err_b), 0);
        check("b_param_tready", 64'(pb_rdy), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prbs_gen_axis.md
PRBS_GEN_AXIS -- requirements
Module: prbs_gen_axis

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, width of the param and output tdata buses.
REQ-002 SHALL have parameter LANES, default 1, PRBS bits generated per symbol tick (1..AXIS_TDATA_WIDTH).
REQ-003 SHALL have parameter VAR, default 0; 0 = fixed config from parameters, 1 = runtime config from the param stream.
REQ-004 SHALL have parameter PRBS_SEL, default 4, reset-time order select.
REQ-005 SHALL have parameter DEFAULT_DIV, default 0, reset-time divider value N.
REQ-006 clk  in  1  clock, 125 MHz.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 S_AXIS_PARAM_tdata  in  AXIS_TDATA_WIDTH  config word: [2:0] sel, [3] invert, [4] clear-status, [31:8] divider N.
REQ-009 S_AXIS_PARAM_tvalid  in  1  config word valid.
REQ-010 S_AXIS_PARAM_tready  out  1  constant 1.
REQ-011 M_AXIS_PRBS_tdata  out  AXIS_TDATA_WIDTH  [LANES-1:0] newest bits, oldest in bit 0; upper bits 0.
REQ-012 M_AXIS_PRBS_tvalid  out  1  beat valid.
REQ-013 M_AXIS_PRBS_tready  in  1  downstream ready.
REQ-014 PRBS  out  1  serial bit = lane LANES-1 of latest step.
REQ-015 sync  out  1  one-cycle pulse at sequence restart.
REQ-016 overflow  out  1  sticky, beat lost to backpressure.
REQ-017 cfg_err  out  1  sticky, reserved sel written.

Function
REQ-018 Divider counter cnt SHALL count 0..N; tick asserted when cnt==N, cnt wraps to 0; N=0 gives a tick every cycle; no derived clocks.
REQ-019 Sel encodings SHALL be 0:PRBS7 (x^7+x^6+1), 1:PRBS9 (x^9+x^5+1), 2:PRBS15 (x^15+x^14+1), 3:PRBS23 (x^23+x^18+1), 4:PRBS31 (x^31+x^28+1).
REQ-020 Each bit step SHALL compute new = s[n-1]^s[t-1] and update s <= {s[n-2:0],new}; output bit = new XOR invert; LANES steps per tick.
REQ-021 On a tick, state, tdata, PRBS and sync SHALL update on the same clk edge (1-cycle latency from tick).
REQ-022 tvalid SHALL assert on each tick and hold until tvalid&&tready; tdata SHALL stay stable while tvalid=1 and tready=0.
REQ-023 A tick while tvalid=1 and tready=0 SHALL overwrite tdata with the new beat and set overflow; the generator never stalls.
REQ-024 A tick coinciding with handshake SHALL keep tvalid=1 with the new beat.
REQ-025 With VAR=1, a param word with sel 0..4 SHALL be staged in a shadow register and applied at the next tick edge, before that tick's step.
REQ-026 A sel change SHALL reload state with the all-ones seed; the divider change SHALL take effect with cnt restarted at 0.
REQ-027 A param word with sel 5..7 SHALL be ignored entirely and SHALL set cfg_err.
REQ-028 Clear-status bit SHALL clear overflow and cfg_err on the cycle after the word is accepted; a simultaneous set event wins.
REQ-029 A later param word SHALL replace an unapplied staged word.
REQ-030 sync SHALL pulse for one cycle on a tick whose updated state equals the seed.
REQ-031 State reaching all-zero SHALL be reloaded with the seed on the next tick.
REQ-032 With VAR=0, param inputs SHALL be ignored and config held at PRBS_SEL, DEFAULT_DIV, invert=0.

Reset
REQ-033 On rst: cnt=0, state=all-ones seed, config=parameter defaults, shadow empty, tvalid=0, tdata=0, PRBS=0, sync=0, overflow=0, cfg_err=0.
REQ-034 Reset mid-beat SHALL drop the pending beat; the first tick after release SHALL produce step one from the seed.

Structure
REQ-035 Package prbs_pkg SHALL hold sel encodings, per-order length/tap constants, seed constant and config field positions.
REQ-036 Sub-module prbs_lfsr_step SHALL implement the combinational LANES-bit advance for a given sel; top holds divider, config staging, output register and status.

Verification
REQ-037 PRBS7, N=0, LANES=1, tready=1: 127-bit period, 64 ones, sync every 127 cycles, first bits 0,0,0,0,0,0,1.
REQ-038 N=9, PRBS31: tick every 10 clk; tvalid pulses once per 10 cycles; PRBS pin constant between ticks.
REQ-039 tready held 0 across two ticks: first beat stable until the second tick, then replaced; overflow=1 until a clear word.
REQ-040 VAR=1, write sel=2 mid-interval: PRBS15 from seed begins at next tick; write sel=6: config unchanged, cfg_err=1.
REQ-041 LANES=8, PRBS9: concatenated beats equal the LANES=1 reference serial stream bit-for-bit over 511 beats.
REQ-042 Assert rst mid-interval with tvalid=1: outputs zero immediately; post-release sequence identical to power-up.
